// File: rtl/zbb_count_unit_pkg.sv
// Shared decode constants, FSM/op encodings and helpers for the Zbb bit-count unit.
package zbb_count_unit_pkg;

    localparam logic [6:0] ZBBOP_CNT   = 7'b0010011;
    localparam logic [2:0] ZBBF3_CNT   = 3'b001;
    localparam logic [6:0] ZBBF7_CNT   = 7'b0110000;
    localparam logic [4:0] ZBBRS2_CLZ  = 5'b00000;
    localparam logic [4:0] ZBBRS2_CTZ  = 5'b00001;
    localparam logic [4:0] ZBBRS2_CPOP = 5'b00010;

    typedef enum logic [1:0] {
        ZBBCNT_IDLE,
        ZBBCNT_RUN,
        ZBBCNT_DONE
    } cnt_state_t;

    typedef enum logic [1:0] {
        CNT_CLZ,
        CNT_CTZ,
        CNT_CPOP
    } cnt_op_t;

    function automatic logic [31:0] bit_reverse(input logic [31:0] x);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            r[i] = x[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/zbb_count_unit_if.sv
// Decoded operand/field bus plus stall/writeback returns between the core and the count unit.
interface zbb_count_unit_if;

    logic        start;
    logic [31:0] din_rs1;
    logic [6:0]  cmdOp;
    logic [2:0]  cmdF3;
    logic [6:0]  cmdF7;
    logic [4:0]  cmdRs2;
    logic        isZbbInstr;
    logic        stall;
    logic        regWrite;
    logic [31:0] dout_rd;

    modport master (
        output start, din_rs1, cmdOp, cmdF3, cmdF7, cmdRs2,
        input  isZbbInstr, stall, regWrite, dout_rd
    );

    modport slave (
        input  start, din_rs1, cmdOp, cmdF3, cmdF7, cmdRs2,
        output isZbbInstr, stall, regWrite, dout_rd
    );

endinterface

// File: rtl/zbb_count_unit_cnt_step.sv
// Combinational per-chunk statistics: popcount, trailing zeros and nonzero flag.
module zbb_cnt_step #(
    parameter int unsigned STEP_BITS = 4
) (
    input  logic [STEP_BITS-1:0] chunk,
    output logic [5:0]           pop,
    output logic [5:0]           tz,
    output logic                 nz
);

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < STEP_BITS; i++) begin
            pop = pop + 6'(chunk[i]);
        end
    end

    // Scan from the top so the lowest set bit wins; an empty chunk reports STEP_BITS.
    always_comb begin
        tz = 6'(STEP_BITS);
        for (int unsigned i = 0; i < STEP_BITS; i++) begin
            if (chunk[STEP_BITS-1-i]) begin
                tz = 6'(STEP_BITS - 1 - i);
            end
        end
    end

    assign nz = |chunk;

endmodule

// File: rtl/zbb_count_unit.sv
// Multi-cycle CLZ/CTZ/CPOP unit: stalls the core for a fixed STEP_BITS-per-cycle scan, then writes rd once.
module zbb_count_unit
    import zbb_count_unit_pkg::*;
#(
    parameter int unsigned STEP_BITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    zbb_count_unit_if.slave    bus
);

    localparam int unsigned N  = 32 / STEP_BITS;
    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

    cnt_state_t    state;
    cnt_op_t       op;
    cnt_op_t       dec_op;
    logic [31:0]   shreg;
    logic [5:0]    count;
    logic          found;
    logic [SW-1:0] step;
    logic          hit;
    logic          accept;
    logic [5:0]    chunk_pop;
    logic [5:0]    chunk_tz;
    logic          chunk_nz;

    always_comb begin
        hit    = 1'b0;
        dec_op = CNT_CLZ;
        if (bus.cmdOp == ZBBOP_CNT && bus.cmdF3 == ZBBF3_CNT && bus.cmdF7 == ZBBF7_CNT) begin
            case (bus.cmdRs2)
                ZBBRS2_CLZ:  begin hit = 1'b1; dec_op = CNT_CLZ;  end
                ZBBRS2_CTZ:  begin hit = 1'b1; dec_op = CNT_CTZ;  end
                ZBBRS2_CPOP: begin hit = 1'b1; dec_op = CNT_CPOP; end
                default:     begin hit = 1'b0; dec_op = CNT_CLZ;  end
            endcase
        end
    end

    assign bus.isZbbInstr = hit;
    assign accept         = bus.start & hit & (state == ZBBCNT_IDLE);

    zbb_cnt_step #(.STEP_BITS(STEP_BITS)) u_step (
        .chunk (shreg[STEP_BITS-1:0]),
        .pop   (chunk_pop),
        .tz    (chunk_tz),
        .nz    (chunk_nz)
    );

    // CLZ reuses the trailing-zero scan on the bit-reversed operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ZBBCNT_IDLE;
            op    <= CNT_CLZ;
            shreg <= '0;
            count <= '0;
            found <= 1'b0;
            step  <= '0;
        end else begin
            case (state)
                ZBBCNT_IDLE: begin
                    if (accept) begin
                        shreg <= (dec_op == CNT_CLZ) ? bit_reverse(bus.din_rs1) : bus.din_rs1;
                        op    <= dec_op;
                        count <= '0;
                        found <= 1'b0;
                        step  <= '0;
                        state <= ZBBCNT_RUN;
                    end
                end
                ZBBCNT_RUN: begin
                    if (op == CNT_CPOP) begin
                        count <= count + chunk_pop;
                    end else if (!found) begin
                        count <= count + chunk_tz;
                        found <= chunk_nz;
                    end
                    shreg <= shreg >> STEP_BITS;
                    step  <= step + SW'(1);
                    if (step == SW'(N - 1)) begin
                        state <= ZBBCNT_DONE;
                    end
                end
                ZBBCNT_DONE: begin
                    state <= ZBBCNT_IDLE;
                end
                default: begin
                    state <= ZBBCNT_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.stall    = 1'b0;
        bus.regWrite = 1'b0;
        bus.dout_rd  = '0;
        case (state)
            ZBBCNT_IDLE: bus.stall = accept;
            ZBBCNT_RUN:  bus.stall = 1'b1;
            ZBBCNT_DONE: begin
                bus.regWrite = 1'b1;
                bus.dout_rd  = {26'b0, count};
            end
            default: bus.stall = 1'b0;
        endcase
    end

endmodule
